pc_next_unit: RTL
=================

Name: pc_next_unit

Overview:
- Parametrised program-counter and next-PC block for the MIPS core.
- Owns the PC register and forms every next-fetch address:
  - sequential +4
  - conditional branch (PC-relative)
  - J/JAL region jump: upper PC bits concatenated with index<<2
  - JR register jump
- Adds stall hold, capture of a redirect that arrives during a stall, an optional architectural delay slot, and JR misalignment detection. Sits between the decode/branch-resolve logic and instruction memory.

Parameters:
ADDR_W, 32, PC and target width (≥ IDX_W+4).
IDX_W, 26, jump index width.
IMM_W, 16, branch offset width (sign-extended to ADDR_W).
RESET_PC, 32'h0040_0000, PC value loaded on reset.
DELAY_SLOT, 0, 1 = one sequential fetch executes before a redirect takes effect.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
stall  in  1  hold PC this cycle.
redirect_valid  in  1  one-cycle request to change flow.
redirect_type  in  2  00 branch, 01 jump, 10 jr, 11 reserved (ignored).
inst_pc  in  ADDR_W  PC of the instruction causing the redirect.
br_offset  in  IMM_W  branch word offset.
j_index  in  IDX_W  jump index.
jr_target  in  ADDR_W  register value for JR.
pc  out  ADDR_W  current fetch address (registered).
pc_plus4  out  ADDR_W  pc+4, combinational from pc.
pend_valid  out  1  a redirect is captured and not yet applied.
redirect_taken  out  1  registered pulse, high the cycle pc first equals a redirect target.
misalign_err  out  1  registered one-cycle pulse, JR target had nonzero low 2 bits.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC.
  - pend_valid, redirect_taken and misalign_err all 0.
  - State returns to RUN; any pending target is discarded immediately.
- Target formation, combinational on the request cycle, all arithmetic modulo 2^ADDR_W, wraps silently:
  - branch: inst_pc+4+(sext(br_offset)<<2).
  - jump: {(inst_pc+4)[ADDR_W-1:IDX_W+2], j_index, 2'b00}.
  - jr: {jr_target[ADDR_W-1:2], 2'b00}. If jr_target[1:0]≠0, misalign_err=1 the next cycle.
  - type 11 is ignored entirely: no capture, no flag.
- Capture: a valid redirect always loads pend_target and sets pend_valid, whether or not stall is high. A newer redirect overwrites an older unapplied one (last wins).
- States:
  - RUN: no redirect outstanding.
  - SLOT: DELAY_SLOT=1 only; the delay-slot fetch is still owed.
  - PEND: target waiting to load.
- Per rising edge, stall=1: pc holds; state and pending target are held, except that capture still occurs.
- Per rising edge, stall=0:
  - RUN, no request: pc<=pc+4.
  - RUN + request, DELAY_SLOT=0: pc<=target, redirect_taken<=1, stay RUN.
  - RUN + request, DELAY_SLOT=1: pc<=pc+4, go SLOT.
  - SLOT: pc<=pend_target, redirect_taken<=1, pend cleared, go RUN.
  - SLOT + new request: new target overwrites pending and is applied this edge.
  - PEND (request captured under stall): on the first unstalled edge, DELAY_SLOT=0 loads pend_target; DELAY_SLOT=1 performs the slot +4 then loads.
- Stall has priority over everything except reset.

Test Plan:
- Reset to RESET_PC=0x00400000, release, 3 free cycles -> pc=0x00400004, 0x00400008, 0x0040000C; pend_valid=0.
- Jump, DELAY_SLOT=0: inst_pc=0x00400010, j_index=0x0100008 -> next pc=0x00400020, redirect_taken=1 for that one cycle.
- Branch: inst_pc=0x00400020, br_offset=0xFFFE -> pc=0x0040001C. Branch at inst_pc=0xFFFFFFF8, offset=0x0002 -> pc wraps to 0x00000004.
- JR jr_target=0x00400033 -> pc=0x00400030, misalign_err pulses exactly one cycle. Request with redirect_type=11 -> pc continues +4 with no flags.
- Stall for 3 cycles; branch request in stall cycle 1 (target 0x00400100), jump in cycle 2 (target 0x00400200) -> pc frozen, pend_valid=1; first unstalled edge gives pc=0x00400200.
- DELAY_SLOT=1, pc=0x00400040, jump to 0x00400080 -> pc sequence 0x00400044 then 0x00400080. rst_n pulsed low while in SLOT -> pc=0x00400000 immediately and the jump is never taken.

Source files
------------

// File: rtl/pc_next_unit.sv
// Program counter and next-fetch address generator: sequential, branch, J/JAL and JR targets.
// pc is registered; redirects captured under stall (last wins) and applied on the first free edge.
module pc_next_unit #(
  parameter int unsigned             ADDR_W     = 32,
  parameter int unsigned             IDX_W      = 26,
  parameter int unsigned             IMM_W      = 16,
  parameter logic [ADDR_W-1:0]       RESET_PC   = 32'h0040_0000,
  parameter int unsigned             DELAY_SLOT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [1:0]        redirect_type,
  input  logic [ADDR_W-1:0] inst_pc,
  input  logic [IMM_W-1:0]  br_offset,
  input  logic [IDX_W-1:0]  j_index,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              pend_valid,
  output logic              redirect_taken,
  output logic              misalign_err
);

  typedef enum logic [1:0] {RUN, SLOT, PEND} state_t;

  localparam logic [1:0] T_BR = 2'b00;
  localparam logic [1:0] T_J  = 2'b01;
  localparam logic [1:0] T_JR = 2'b10;
  localparam logic [ADDR_W-1:0] FOUR = {{(ADDR_W-3){1'b0}}, 3'd4};

  state_t            state;
  logic [ADDR_W-1:0] pend_target;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] br_disp;
  logic [ADDR_W-1:0] target;
  logic              req;
  logic              jr_bad;

  assign pc_plus4 = pc + FOUR;
  assign seq_pc   = inst_pc + FOUR;
  // Word offset sign-extended, then scaled to bytes.
  assign br_disp  = {{(ADDR_W-IMM_W-2){br_offset[IMM_W-1]}}, br_offset, 2'b00};
  assign req      = redirect_valid && (redirect_type != 2'b11);
  assign jr_bad   = redirect_valid && (redirect_type == T_JR) && (jr_target[1:0] != 2'b00);

  always_comb begin
    target = '0;
    case (redirect_type)
      T_BR:    target = seq_pc + br_disp;
      T_J:     target = {seq_pc[ADDR_W-1:IDX_W+2], j_index, 2'b00};
      T_JR:    target = {jr_target[ADDR_W-1:2], 2'b00};
      default: target = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      pc             <= RESET_PC;
      pend_target    <= '0;
      pend_valid     <= 1'b0;
      redirect_taken <= 1'b0;
      misalign_err   <= 1'b0;
    end else begin
      misalign_err   <= jr_bad;
      redirect_taken <= 1'b0;
      if (stall) begin
        // pc frozen, but a redirect is still captured so it is not lost.
        if (req) begin
          pend_target <= target;
          pend_valid  <= 1'b1;
          if (state == RUN) state <= PEND;
        end
      end else begin
        case (state)
          RUN: begin
            if (req && DELAY_SLOT != 0) begin
              pc          <= pc_plus4;
              pend_target <= target;
              pend_valid  <= 1'b1;
              state       <= SLOT;
            end else if (req) begin
              pc             <= target;
              redirect_taken <= 1'b1;
              pend_valid     <= 1'b0;
            end else begin
              pc <= pc_plus4;
            end
          end
          SLOT: begin
            pc             <= req ? target : pend_target;
            redirect_taken <= 1'b1;
            pend_valid     <= 1'b0;
            state          <= RUN;
          end
          PEND: begin
            if (DELAY_SLOT != 0) begin
              pc          <= pc_plus4;
              pend_target <= req ? target : pend_target;
              state       <= SLOT;
            end else begin
              pc             <= req ? target : pend_target;
              redirect_taken <= 1'b1;
              pend_valid     <= 1'b0;
              state          <= RUN;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule
